// File: rtl/cpu_control_fsm_if.sv
// Control bus between the CPU control FSM and the datapath.
// The master side (the FSM) receives the opcode and condition code from the datapath
// and drives the load, tri-state, memory and ALU-select controls back to it.
interface cpu_control_fsm_if;
    logic [7:0] ir_op;
    logic       cc;
    logic       Lmar, Lir, Lbuff, Lpc, Lsp, Lreg, Lmdr, Lalu;
    logic       Tpc, Tmdr, T1, Tbuff, Tsp, Treg, Tlabel;
    logic       wr, rd;
    logic [2:0] fsel;
    logic       instr_done, halted;

    modport master (
        input  ir_op, cc,
        output Lmar, Lir, Lbuff, Lpc, Lsp, Lreg, Lmdr, Lalu,
        output Tpc, Tmdr, T1, Tbuff, Tsp, Treg, Tlabel,
        output wr, rd, fsel, instr_done, halted
    );

    modport slave (
        output ir_op, cc,
        input  Lmar, Lir, Lbuff, Lpc, Lsp, Lreg, Lmdr, Lalu,
        input  Tpc, Tmdr, T1, Tbuff, Tsp, Treg, Tlabel,
        input  wr, rd, fsel, instr_done, halted
    );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control unit: fetch, then per-opcode execute sequences.
// State advances on posedge; the datapath loads on the following negedge.
module cpu_control_fsm (
    input  logic                clk,
    input  logic                rst,
    cpu_control_fsm_if.master   bus
);

    typedef enum logic [4:0] {
        S_RST, S_F0, S_F1, S_F2, S_F3,
        S_A0, S_A1, S_A2, S_A3,
        S_L0, S_L1, S_L2,
        S_S0, S_S1, S_S2,
        S_J0, S_HALT
    } state_t;

    typedef struct packed {
        logic       lmar, lir, lbuff, lpc, lreg, lmdr, lalu;
        logic       tpc, tmdr, t1, tbuff, treg, tlabel;
        logic       wr, rd;
        logic [2:0] fsel;
        logic       done, halted;
        logic       jc_en;   // J0 of JC: Lpc/Tlabel gated by live cc
    } ctl_t;

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    ctl_t       ctl_q;

    logic unused_ir_low;
    assign unused_ir_low = ^bus.ir_op[3:0];

    // Control word for a given state; opcode selects ALU function and JMP/JC flavour.
    function automatic ctl_t decode(input state_t s, input logic [3:0] op);
        ctl_t c;
        c = '0;
        case (s)
            S_F0:   begin c.tpc = 1'b1; c.lmar = 1'b1; end
            S_F1:   begin c.rd = 1'b1; c.t1 = 1'b1; c.lbuff = 1'b1; end
            S_F2:   begin c.tpc = 1'b1; c.tbuff = 1'b1; c.fsel = 3'b001; c.lpc = 1'b1; end
            S_F3:   begin c.tmdr = 1'b1; c.lir = 1'b1; end
            S_A0, S_L0, S_S0:
                    begin c.tlabel = 1'b1; c.lmar = 1'b1; end
            S_A1, S_L1:
                    c.rd = 1'b1;
            S_A2:   begin c.tmdr = 1'b1; c.lbuff = 1'b1; end
            S_A3:   begin
                        c.treg = 1'b1; c.tbuff = 1'b1; c.fsel = op[2:0];
                        c.lreg = 1'b1; c.lalu = 1'b1; c.done = 1'b1;
                    end
            S_L2:   begin c.tmdr = 1'b1; c.lreg = 1'b1; c.done = 1'b1; end
            S_S1:   begin c.treg = 1'b1; c.lmdr = 1'b1; end
            S_S2:   begin c.wr = 1'b1; c.done = 1'b1; end
            S_J0:   begin
                        c.done = 1'b1;
                        if (op == 4'b1000) begin
                            c.tlabel = 1'b1; c.lpc = 1'b1;
                        end else begin
                            c.jc_en = 1'b1;
                        end
                    end
            S_HALT: c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection; the opcode is captured as F3 is left.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_RST: state_d = S_F0;
            S_F0:  state_d = S_F1;
            S_F1:  state_d = S_F2;
            S_F2:  state_d = S_F3;
            S_F3:  begin
                op_d = bus.ir_op[7:4];
                case (bus.ir_op[7:4])
                    4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101: state_d = S_A0;
                    4'b0110:          state_d = S_L0;
                    4'b0111:          state_d = S_S0;
                    4'b1000, 4'b1001: state_d = S_J0;
                    4'b1111:          state_d = S_HALT;
                    default:          state_d = S_F0;
                endcase
            end
            S_A0:  state_d = S_A1;
            S_A1:  state_d = S_A2;
            S_A2:  state_d = S_A3;
            S_L0:  state_d = S_L1;
            S_L1:  state_d = S_L2;
            S_S0:  state_d = S_S1;
            S_S1:  state_d = S_S2;
            S_HALT: state_d = S_HALT;
            default: state_d = S_F0;
        endcase
    end

    // State, latched opcode and registered control word; reset clears all outputs at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RST;
            op_q    <= '0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctl_q   <= decode(state_d, op_d);
        end
    end

    // F3 retires NOP, undefined and HALT opcodes itself; IR is only valid within F3.
    logic f3_retire;
    assign f3_retire = (state_q == S_F3) &&
                       ((bus.ir_op[7:4] == 4'b0000) || (bus.ir_op[7:4] >= 4'b1010));

    assign bus.Lmar       = ctl_q.lmar;
    assign bus.Lir        = ctl_q.lir;
    assign bus.Lbuff      = ctl_q.lbuff;
    assign bus.Lpc        = ctl_q.lpc | (ctl_q.jc_en & bus.cc);
    assign bus.Lsp        = 1'b0;
    assign bus.Lreg       = ctl_q.lreg;
    assign bus.Lmdr       = ctl_q.lmdr;
    assign bus.Lalu       = ctl_q.lalu;
    assign bus.Tpc        = ctl_q.tpc;
    assign bus.Tmdr       = ctl_q.tmdr;
    assign bus.T1         = ctl_q.t1;
    assign bus.Tbuff      = ctl_q.tbuff;
    assign bus.Tsp        = 1'b0;
    assign bus.Treg       = ctl_q.treg;
    assign bus.Tlabel     = ctl_q.tlabel | (ctl_q.jc_en & bus.cc);
    assign bus.wr         = ctl_q.wr;
    assign bus.rd         = ctl_q.rd;
    assign bus.fsel       = ctl_q.fsel;
    assign bus.instr_done = ctl_q.done | f3_retire;
    assign bus.halted     = ctl_q.halted;

endmodule

// File: doc/cpu_control_fsm.md
CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 clk  in  1  system clock; state advances on posedge; datapath registers load on the following negedge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 ir_op  in  8  IR[15:8] from datapath; opcode = ir_op[7:4].
REQ-004 cc  in  1  condition-code bit from datapath status selection.
REQ-005 Lmar  out  1  load MAR from Z bus.
REQ-006 Lir  out  1  load IR from Z bus.
REQ-007 Lbuff  out  1  load BUFF from A bus.
REQ-008 Lpc  out  1  load PC from Z bus.
REQ-009 Lsp  out  1  load SP; tied 0 in this revision.
REQ-010 Lreg  out  1  write register bank entry IR[7:5].
REQ-011 Lmdr  out  1  load MDR from Z bus.
REQ-012 Lalu  out  1  update status flags.
REQ-013 Tpc  out  1  drive PC onto A bus.
REQ-014 Tmdr  out  1  drive MDR onto A bus.
REQ-015 T1  out  1  drive constant 1 onto A bus.
REQ-016 Tbuff  out  1  drive BUFF to ALU B input.
REQ-017 Tsp  out  1  drive SP; tied 0 in this revision.
REQ-018 Treg  out  1  drive register IR[7:5] onto A bus.
REQ-019 Tlabel  out  1  drive zero-extended IR[11:0] onto A bus.
REQ-020 wr  out  1  memory write M[MAR] <- MDR.
REQ-021 rd  out  1  memory read MDR <- M[MAR].
REQ-022 fsel  out  3  ALU function: 000 PASSA, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR.
REQ-023 instr_done  out  1  one-cycle pulse in the final state of each instruction.
REQ-024 halted  out  1  high while in HALT.

Function
REQ-025 Moore FSM: outputs decode from the state register and opcode only; at most one A-bus driver asserted per state; all outputs not listed for a state are 0.
REQ-026 Fetch: F0 {Tpc, fsel=000, Lmar}; F1 {rd, T1, Lbuff}; F2 {Tpc, Tbuff, fsel=001, Lpc}; F3 {Tmdr, fsel=000, Lir}.
REQ-027 At the posedge ending F3, the next state is selected from the opcode that IR loaded on the F3 negedge.
REQ-028 ALU ops 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR: A0 {Tlabel, Lmar}; A1 {rd}; A2 {Tmdr, Lbuff}; A3 {Treg, Tbuff, fsel=op code, Lreg, Lalu, instr_done}; 8 cycles total.
REQ-029 0110 LOAD: L0 {Tlabel, Lmar}; L1 {rd}; L2 {Tmdr, Lreg, instr_done}; 7 cycles.
REQ-030 0111 STORE: S0 {Tlabel, Lmar}; S1 {Treg, Lmdr}; S2 {wr, instr_done}; 7 cycles; rd=0 throughout S2.
REQ-031 1000 JMP: J0 {Tlabel, Lpc, instr_done}; 5 cycles.
REQ-032 1001 JC: J0 asserts {Tlabel, Lpc} only when cc=1, with instr_done asserted regardless of cc; cc is sampled combinationally in J0.
REQ-033 0000 NOP and undefined opcodes 1010-1110: F3 asserts instr_done and the FSM returns to F0; 4 cycles.
REQ-034 1111 HALT: enters HALT (all outputs 0, halted=1, instr_done pulsed once on the F3 posedge); remains in HALT until rst.
REQ-035 All execute final states return to F0.
REQ-036 wr and rd are never high in the same cycle; Lmdr and rd are never high in the same cycle.

Reset
REQ-037 rst=1 forces state RST immediately, independent of clk, and forces all outputs, including fsel, instr_done and halted, to 0 while rst is high.
REQ-038 The first posedge after rst deasserts moves RST to F0; deasserting rst mid-instruction or mid-HALT restarts at fetch.

Verification
REQ-039 rst high for 3 cycles, then low: all outputs 0 during reset; after the first posedge, Tpc=Lmar=1 and fsel=000.
REQ-040 ir_op=0x10 (ADD), from F0: output sequence matches REQ-026/028; in A3, Treg=Tbuff=Lreg=Lalu=1, fsel=001, instr_done=1; the next state is F0; 8 cycles total.
REQ-041 ir_op=0x90 (JC) run twice: with cc=0, J0 has Lpc=Tlabel=0 and instr_done=1; with cc=1, J0 has Lpc=Tlabel=1.
REQ-042 ir_op=0x70 (STORE): S1 has Treg=Lmdr=1; S2 has wr=1, rd=0; at no point are wr and rd high together.
REQ-043 ir_op=0xF0: halted=1 and outputs stay 0 for 10 cycles; asserting rst mid-HALT clears halted asynchronously, and fetch resumes after release.
REQ-044 Assert rst during A1 of an ADD: rd drops to 0 without waiting for a clock edge; ir_op=0xB0 is then treated as NOP and returns to F0 after F3.
